ahblite_master_arbiter: RTL and testbench
=========================================

AHBLITE_MASTER_ARBITER -- requirements
Module: ahblite_master_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, range 1..255: the number of stalled cycles after which a waiting master flags a timeout.
REQ-002 HCLK  input  1  clock; all state updates on the rising edge.
REQ-003 aresetn  input  1  reset, asynchronous, active-low.
REQ-004 M0_HTRANS  input  2  master 0 transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-005 M0_HMASTLOCK  input  1  master 0 locked-sequence indicator.
REQ-006 M1_HTRANS  input  2  master 1 transfer type.
REQ-007 M1_HMASTLOCK  input  1  master 1 locked-sequence indicator.
REQ-008 S_HREADY  input  1  ready from the shared slave path.
REQ-009 M0_HREADY  output  1  ready returned to master 0.
REQ-010 M1_HREADY  output  1  ready returned to master 1.
REQ-011 ADDR_GNT  output  2  one-hot address-phase owner (bit0 = M0, bit1 = M1), 00 = no owner; drives the address/control mux.
REQ-012 DATA_SEL  output  2  one-hot data-phase owner; drives the HWDATA/HRDATA mux.
REQ-013 WAIT_TIMEOUT  output  1  one-cycle pulse when a non-owner has waited WAIT_MAX cycles.

Function
REQ-014 REQx SHALL be Mx_HTRANS[1]; BUSY SHALL NOT be a request but SHALL keep an existing ownership.
REQ-015 The state machine SHALL have three states: IDLE (ADDR_GNT=00), OWN0 (ADDR_GNT=01) and OWN1 (ADDR_GNT=10); ADDR_GNT SHALL be decoded from the registered state only.
REQ-016 The state and the last-grant pointer SHALL update only on edges where S_HREADY=1; with S_HREADY=0 all state SHALL hold.
REQ-017 From IDLE:
- REQ0 & REQ1 -> the master not equal to the last-grant pointer;
- single request -> that master;
- none -> stay IDLE.
REQ-018 An owner SHALL release only when its HTRANS=IDLE and its HMASTLOCK=0; while it holds BUSY/NONSEQ/SEQ, or IDLE with HMASTLOCK=1, ownership SHALL hold regardless of the other master.
REQ-019 On release from OWNx:
- other master requesting -> OWN(other);
- otherwise -> IDLE.
REQ-020 The last-grant pointer SHALL be loaded with the new owner on every entry to OWN0/OWN1; its reset value SHALL be M1, so M0 wins the first simultaneous request.
REQ-021 Arbitration latency SHALL be exactly one cycle from IDLE: a request seen in IDLE is granted on the next cycle, and the requester sees Mx_HREADY=0 in the request cycle.
REQ-022 Mx_HREADY SHALL be combinational:
- S_HREADY when ADDR_GNT[x]=1 or DATA_SEL[x]=1;
- else 0 when REQx=1 (stall; the master holds its address);
- else 1.
REQ-023 DATA_SEL SHALL be loaded on each S_HREADY=1 edge with ADDR_GNT AND {REQ1,REQ0}, so IDLE/BUSY address phases create no data phase.
REQ-024 A previous owner SHALL keep DATA_SEL through its final data phase while the new owner drives the address; ADDR_GNT and DATA_SEL SHALL each never have both bits set.
REQ-025 An 8-bit wait counter SHALL increment each cycle a non-owner has REQ=1 with ADDR_GNT[x]=0, and SHALL clear when that master is granted or drops REQ.
REQ-026 The wait counter SHALL saturate at WAIT_MAX, and WAIT_TIMEOUT SHALL pulse for one cycle on the transition to WAIT_MAX; no further pulse occurs until the counter clears.
REQ-027 WAIT_TIMEOUT SHALL be status only and SHALL NOT alter arbitration.

Reset
REQ-028 On aresetn low, immediately and regardless of HCLK: state=IDLE, ADDR_GNT=00, DATA_SEL=00, last-grant pointer=M1, wait counter=0, WAIT_TIMEOUT=0.
REQ-029 During reset, Mx_HREADY SHALL follow REQ-022 with ADDR_GNT=DATA_SEL=00.
REQ-030 Reset asserted mid-transfer SHALL abandon ownership; after deassertion, arbitration SHALL restart from IDLE with no residual grant.

Verification
REQ-031 Both masters NONSEQ in the same cycle after reset, S_HREADY=1:
- next cycle ADDR_GNT=01 and M1_HREADY=0;
- one cycle later DATA_SEL=01.
REQ-032 M0 owner issues SEQ, SEQ then IDLE with lock=0 while M1 requests:
- ADDR_GNT goes 01->10 on the edge after IDLE;
- DATA_SEL=01 for M0's last beat, then 10.
REQ-033 M0 owner with HMASTLOCK=1 and HTRANS=IDLE for 5 cycles while M1 requests: ADDR_GNT stays 01 and M1_HREADY stays 0.
REQ-034 S_HREADY=0 for 3 cycles at the release point: no state or DATA_SEL change until S_HREADY returns to 1.
REQ-035 WAIT_MAX=4 with M1 stalled behind a long M0 burst: WAIT_TIMEOUT pulses exactly once, in the 4th stalled cycle.
REQ-036 aresetn pulsed low during OWN1 with DATA_SEL=10: outputs immediately ADDR_GNT=00 and DATA_SEL=00; after reset, simultaneous requests grant M0.

Source files
------------

// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: one-hot address and data phase owner select,
// locked-sequence hold, round-robin tie break and a wait timeout flag.
module ahblite_master_arbiter #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       HCLK,
    input  logic       aresetn,
    input  logic [1:0] M0_HTRANS,
    input  logic       M0_HMASTLOCK,
    input  logic [1:0] M1_HTRANS,
    input  logic       M1_HMASTLOCK,
    input  logic       S_HREADY,
    output logic       M0_HREADY,
    output logic       M1_HREADY,
    output logic [1:0] ADDR_GNT,
    output logic [1:0] DATA_SEL,
    output logic       WAIT_TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] WMAX = 8'(WAIT_MAX);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] data_sel_q, data_sel_d;
    logic [7:0] wait0_q, wait0_d;
    logic [7:0] wait1_q, wait1_d;

    logic       req0, req1;
    logic       rel0, rel1;
    logic       inc0, inc1;
    logic       to0, to1;
    logic [1:0] gnt;

    assign req0 = M0_HTRANS[1];
    assign req1 = M1_HTRANS[1];
    assign rel0 = (M0_HTRANS == 2'b00) && !M0_HMASTLOCK;
    assign rel1 = (M1_HTRANS == 2'b00) && !M1_HMASTLOCK;

    always_comb begin
        gnt = 2'b00;
        unique case (state_q)
            ST_OWN0: gnt = 2'b01;
            ST_OWN1: gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // last_q = 1 means M1 was granted most recently
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (S_HREADY) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req0 && req1)
                        state_d = last_q ? ST_OWN0 : ST_OWN1;
                    else if (req0)
                        state_d = ST_OWN0;
                    else if (req1)
                        state_d = ST_OWN1;
                end
                ST_OWN0: begin
                    if (rel0)
                        state_d = req1 ? ST_OWN1 : ST_IDLE;
                end
                ST_OWN1: begin
                    if (rel1)
                        state_d = req0 ? ST_OWN0 : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d != state_q) begin
                if (state_d == ST_OWN0)
                    last_d = 1'b0;
                else if (state_d == ST_OWN1)
                    last_d = 1'b1;
            end
        end
    end

    always_comb begin
        data_sel_d = data_sel_q;
        if (S_HREADY)
            data_sel_d = gnt & {req1, req0};
    end

    assign inc0 = req0 && !gnt[0];
    assign inc1 = req1 && !gnt[1];

    always_comb begin
        wait0_d = wait0_q;
        wait1_d = wait1_q;
        if (S_HREADY) begin
            if (inc0)
                wait0_d = (wait0_q >= WMAX) ? WMAX : wait0_q + 8'd1;
            else
                wait0_d = 8'd0;
            if (inc1)
                wait1_d = (wait1_q >= WMAX) ? WMAX : wait1_q + 8'd1;
            else
                wait1_d = 8'd0;
        end
    end

    // Pulse on the stalled cycle whose edge moves the counter onto WAIT_MAX
    assign to0 = S_HREADY && inc0 && (wait0_q == WMAX - 8'd1);
    assign to1 = S_HREADY && inc1 && (wait1_q == WMAX - 8'd1);

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            data_sel_q <= 2'b00;
            wait0_q    <= 8'd0;
            wait1_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            data_sel_q <= data_sel_d;
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
        end
    end

    assign ADDR_GNT     = gnt;
    assign DATA_SEL     = data_sel_q;
    assign WAIT_TIMEOUT = aresetn && (to0 || to1);

    always_comb begin
        M0_HREADY = 1'b1;
        M1_HREADY = 1'b1;
        if (gnt[0] || data_sel_q[0])
            M0_HREADY = S_HREADY;
        else if (req0)
            M0_HREADY = 1'b0;
        if (gnt[1] || data_sel_q[1])
            M1_HREADY = S_HREADY;
        else if (req1)
            M1_HREADY = 1'b0;
    end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Directed bench for ahblite_master_arbiter: stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_ahblite_master_arbiter;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic       HCLK;
    logic       aresetn;
    logic [1:0] M0_HTRANS;
    logic       M0_HMASTLOCK;
    logic [1:0] M1_HTRANS;
    logic       M1_HMASTLOCK;
    logic       S_HREADY;
    logic       M0_HREADY;
    logic       M1_HREADY;
    logic [1:0] ADDR_GNT;
    logic [1:0] DATA_SEL;
    logic       WAIT_TIMEOUT;

    typedef struct {
        int         id;
        logic [6:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vid = 0;

    ahblite_master_arbiter #(.WAIT_MAX(4)) dut (
        .HCLK         (HCLK),
        .aresetn      (aresetn),
        .M0_HTRANS    (M0_HTRANS),
        .M0_HMASTLOCK (M0_HMASTLOCK),
        .M1_HTRANS    (M1_HTRANS),
        .M1_HMASTLOCK (M1_HMASTLOCK),
        .S_HREADY     (S_HREADY),
        .M0_HREADY    (M0_HREADY),
        .M1_HREADY    (M1_HREADY),
        .ADDR_GNT     (ADDR_GNT),
        .DATA_SEL     (DATA_SEL),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // exp packs {ADDR_GNT, DATA_SEL, M0_HREADY, M1_HREADY, WAIT_TIMEOUT}
    task automatic vec(
        input logic [1:0] t0, input logic l0,
        input logic [1:0] t1, input logic l1,
        input logic hr, input logic rs,
        input logic [1:0] g, input logic [1:0] s,
        input logic r0, input logic r1, input logic to
    );
        exp_t e;
        @(posedge HCLK);
        #1;
        M0_HTRANS    = t0;
        M0_HMASTLOCK = l0;
        M1_HTRANS    = t1;
        M1_HMASTLOCK = l1;
        S_HREADY     = hr;
        aresetn      = rs;
        e.id  = vid;
        e.exp = {g, s, r0, r1, to};
        q.push_back(e);
        vid++;
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        logic [6:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {ADDR_GNT, DATA_SEL, M0_HREADY, M1_HREADY, WAIT_TIMEOUT};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL vec%0d gnt,sel,r0,r1,to got %b want %b",
                         e.id, act, e.exp);
            end
        end
    end

    initial begin
        aresetn      = 1'b0;
        M0_HTRANS    = I;
        M0_HMASTLOCK = 1'b0;
        M1_HTRANS    = I;
        M1_HMASTLOCK = 1'b0;
        S_HREADY     = 1'b1;

        // reset state and HREADY during reset
        vec(I,0,I,0,1,0, 2'b00,2'b00,1,1,0);
        vec(N,0,I,0,1,0, 2'b00,2'b00,0,1,0);

        // simultaneous request, M0 burst ends, handover to M1, timeout
        vec(N,0,N,0,1,1, 2'b00,2'b00,0,0,0);
        vec(S,0,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(S,0,N,0,1,1, 2'b01,2'b01,1,0,0);
        vec(I,0,N,0,1,1, 2'b01,2'b01,1,0,1);
        vec(I,0,S,0,1,1, 2'b10,2'b00,1,1,0);
        vec(I,0,I,0,1,1, 2'b10,2'b10,1,1,0);
        vec(I,0,I,0,1,1, 2'b00,2'b00,1,1,0);

        // locked idle hold, single timeout pulse, slave stall at release
        vec(N,0,I,0,1,1, 2'b00,2'b00,0,1,0);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,1);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,1,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,0,N,0,0,1, 2'b01,2'b00,0,0,0);
        vec(I,0,N,0,0,1, 2'b01,2'b00,0,0,0);
        vec(I,0,N,0,0,1, 2'b01,2'b00,0,0,0);
        vec(I,0,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,0,S,0,1,1, 2'b10,2'b00,1,1,0);
        vec(I,0,S,0,0,1, 2'b10,2'b10,1,0,0);

        // reset during OWN1 with DATA_SEL=10, then restart
        vec(I,0,S,0,1,1, 2'b10,2'b10,1,1,0);
        vec(I,0,S,0,1,0, 2'b00,2'b00,1,0,0);
        vec(N,0,N,0,1,0, 2'b00,2'b00,0,0,0);
        vec(N,0,N,0,1,1, 2'b00,2'b00,0,0,0);
        vec(N,0,N,0,1,1, 2'b01,2'b00,1,0,0);
        vec(I,0,N,0,1,1, 2'b01,2'b01,1,0,0);
        vec(I,0,I,0,1,1, 2'b10,2'b00,1,1,0);
        vec(I,0,I,0,1,1, 2'b00,2'b00,1,1,0);

        // BUSY keeps ownership and creates no data phase
        vec(I,0,N,0,1,1, 2'b00,2'b00,1,0,0);
        vec(N,0,B,0,1,1, 2'b10,2'b00,0,1,0);
        vec(N,0,I,0,1,1, 2'b10,2'b00,0,1,0);
        vec(I,0,I,0,1,1, 2'b01,2'b00,1,1,0);
        vec(I,0,I,0,1,1, 2'b00,2'b00,1,1,0);

        @(posedge HCLK);
        @(negedge HCLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
